// File: rtl/iqueue_arbiter_if.sv
// Queue-side (empty/data/pop/flush) and issue-side (valid/data/qid/ready/busy) bundle for
// iqueue_arbiter; i_hi_prio is present only when IQUEUE_ARB_PRIO_EN is defined.
`ifndef COE_WIDTH
`define COE_WIDTH 32
`endif

interface iqueue_arbiter_if #(
   parameter int unsigned NUM_Q  = 4,
   parameter int unsigned DWIDTH = `COE_WIDTH,
   parameter int unsigned QW     = $clog2(NUM_Q)
);
   logic [NUM_Q-1:0]        i_empty;
   logic [NUM_Q*DWIDTH-1:0] i_data;
   logic [NUM_Q-1:0]        o_pop;
   logic                    i_flush;
   logic                    o_valid;
   logic [DWIDTH-1:0]       o_data;
   logic [QW-1:0]           o_qid;
   logic                    i_ready;
   logic                    o_busy;
`ifdef IQUEUE_ARB_PRIO_EN
   logic [NUM_Q-1:0]        i_hi_prio;
`endif

   // master: the arbiter itself; slave: queues plus issue consumer.
   modport master (
`ifdef IQUEUE_ARB_PRIO_EN
      input  i_hi_prio,
`endif
      input  i_empty, i_data, i_flush, i_ready,
      output o_pop, o_valid, o_data, o_qid, o_busy
   );

   modport slave (
`ifdef IQUEUE_ARB_PRIO_EN
      output i_hi_prio,
`endif
      output i_empty, i_data, i_flush, i_ready,
      input  o_pop, o_valid, o_data, o_qid, o_busy
   );
endinterface

// File: rtl/iqueue_arbiter.sv
// Round-robin drain of NUM_Q BRAM-backed queues into one issue port with credit-limited buffering.
// Optional IQUEUE_ARB_PRIO_EN adds a high-priority class searched before the normal class.
`ifndef COE_WIDTH
`define COE_WIDTH 32
`endif
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

module iqueue_arbiter #(
   parameter int unsigned NUM_Q             = 4,
   parameter int unsigned DWIDTH            = `COE_WIDTH,
   parameter int unsigned COMMON_BRAM_DELAY = `COMMON_BRAM_DELAY,
   parameter int unsigned QW                = $clog2(NUM_Q),
   parameter int unsigned OBUF_DEPTH        = COMMON_BRAM_DELAY + 2
) (
   input logic              clk,
   input logic              rst_n,
   iqueue_arbiter_if.master bus
);
   localparam int unsigned D  = COMMON_BRAM_DELAY;
   localparam int unsigned CW = $clog2(OBUF_DEPTH + 1);
   localparam int unsigned AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

   logic [QW-1:0]     rr_ptr;
   logic [CW-1:0]     inflight_cnt;
   logic [CW-1:0]     obuf_cnt;
   logic [D-1:0]      pipe_v;
   logic [QW-1:0]     pipe_q [D];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DWIDTH-1:0] obuf_data [OBUF_DEPTH];
   logic [QW-1:0]     obuf_qid  [OBUF_DEPTH];

   logic [NUM_Q-1:0]  hi_prio;
   logic [NUM_Q-1:0]  req_hi;
   logic [NUM_Q-1:0]  req_lo;
   logic [QW:0]       idx;
   logic [QW-1:0]     grant_q;
   logic              grant_any;
   logic              credit;
   logic              pop_ok;
   logic              exit_v;
   logic [QW-1:0]     exit_q;
   logic              wr_en;
   logic              rd_en;
   logic [DWIDTH-1:0] wr_data;

`ifdef IQUEUE_ARB_PRIO_EN
   assign hi_prio = bus.i_hi_prio;
`else
   assign hi_prio = '0;
`endif

   assign req_hi = ~bus.i_empty & hi_prio;
   assign req_lo = ~bus.i_empty & ~hi_prio;

   // Descending scans so the lowest offset from rr_ptr wins; the high class overrides the low one.
   always_comb begin
      grant_q   = rr_ptr;
      grant_any = 1'b0;
      idx       = '0;
      for (int k = int'(NUM_Q) - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (QW+1)'(k);
         if (idx >= (QW+1)'(NUM_Q)) idx = idx - (QW+1)'(NUM_Q);
         if (req_lo[idx[QW-1:0]]) begin
            grant_q   = idx[QW-1:0];
            grant_any = 1'b1;
         end
      end
      for (int k = int'(NUM_Q) - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (QW+1)'(k);
         if (idx >= (QW+1)'(NUM_Q)) idx = idx - (QW+1)'(NUM_Q);
         if (req_hi[idx[QW-1:0]]) begin
            grant_q   = idx[QW-1:0];
            grant_any = 1'b1;
         end
      end
   end

   // A dequeue in the same cycle is deliberately not credited back.
   assign credit = ({1'b0, inflight_cnt} + {1'b0, obuf_cnt}) < (CW+1)'(OBUF_DEPTH);
   assign pop_ok = rst_n && !bus.i_flush && credit && grant_any;

   always_comb begin
      bus.o_pop = '0;
      if (pop_ok) bus.o_pop[grant_q] = 1'b1;
   end

   assign exit_v = pipe_v[D-1];
   assign exit_q = pipe_q[D-1];

   always_comb begin
      wr_data = '0;
      for (int q = 0; q < int'(NUM_Q); q++) begin
         if (exit_q == QW'(q)) wr_data = bus.i_data[q*DWIDTH +: DWIDTH];
      end
   end

   assign bus.o_valid = (obuf_cnt != '0);
   assign wr_en       = exit_v && !bus.i_flush;
   assign rd_en       = bus.o_valid && bus.i_ready;
   assign bus.o_data  = bus.o_valid ? obuf_data[rd_ptr] : '0;
   assign bus.o_qid   = bus.o_valid ? obuf_qid[rd_ptr] : '0;
   assign bus.o_busy  = (inflight_cnt != '0) || (obuf_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         inflight_cnt <= '0;
         obuf_cnt     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         pipe_v       <= '0;
         for (int s = 0; s < int'(D); s++) pipe_q[s] <= '0;
      end else begin
         if (pop_ok) rr_ptr <= (grant_q == QW'(NUM_Q - 1)) ? '0 : grant_q + 1'b1;
         for (int s = int'(D) - 1; s > 0; s--) begin
            pipe_v[s] <= pipe_v[s-1];
            pipe_q[s] <= pipe_q[s-1];
         end
         pipe_v[0] <= pop_ok;
         pipe_q[0] <= grant_q;
         if (bus.i_flush) begin
            inflight_cnt <= '0;
            obuf_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pipe_v       <= '0;
         end else begin
            inflight_cnt <= inflight_cnt + CW'(pop_ok) - CW'(exit_v);
            if (wr_en && !rd_en) obuf_cnt <= obuf_cnt + 1'b1;
            else if (!wr_en && rd_en) obuf_cnt <= obuf_cnt - 1'b1;
            if (wr_en) wr_ptr <= (wr_ptr == AW'(OBUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == AW'(OBUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
      end
   end

   // Storage only; validity is tracked by obuf_cnt so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         obuf_data[wr_ptr] <= wr_data;
         obuf_qid[wr_ptr]  <= exit_q;
      end
   end

   obuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && obuf_cnt == CW'(OBUF_DEPTH)));

endmodule

// File: tb/tb_iqueue_arbiter.sv
// Directed bench for iqueue_arbiter (NUM_Q=4, delay 2, DWIDTH=32) with a behavioural queue/BRAM
// model; define IQUEUE_ARB_PRIO_EN to also exercise the priority class.
module tb_iqueue_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   pushed [4];
   int   popped [4];
   logic [31:0] dly0 [4];
   logic [31:0] dly1 [4];

   int t4_pop [14] = '{8, 1, 2, 4, 0, 0, 8, 1, 2, 4, 0, 0, 0, 0};
   int t4_q   [14] = '{-1, -1, -1, 3, 3, 3, 0, 1, 2, 3, 0, 1, 2, -1};
   int t4_i   [14] = '{0, 0, 0, 2, 2, 2, 2, 2, 5, 3, 3, 3, 6, 0};

   iqueue_arbiter_if #(.NUM_Q(4), .DWIDTH(32)) bus ();

   iqueue_arbiter #(
      .NUM_Q            (4),
      .DWIDTH           (32),
      .COMMON_BRAM_DELAY(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input int q, input int i);
      word = 32'hA500_0000 | 32'(q << 8) | 32'(i);
   endfunction

   // Queue model: empty follows pop count; read data appears two cycles after the pop.
   initial for (int q = 0; q < 4; q++) popped[q] = 0;
   always @(posedge clk) begin
      for (int q = 0; q < 4; q++) begin
         if (bus.o_pop[q]) begin
            popped[q] <= popped[q] + 1;
            dly0[q]   <= word(q, popped[q]);
         end
         dly1[q] <= dly0[q];
      end
   end

   always_comb begin
      bus.i_empty = '0;
      bus.i_data  = '0;
      for (int q = 0; q < 4; q++) begin
         bus.i_empty[q]        = (pushed[q] == popped[q]);
         bus.i_data[q*32 +: 32] = dly1[q];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_issue(input string tag, input int q, input int i);
      check({tag, " valid"}, 32'(bus.o_valid), (q >= 0) ? 32'd1 : 32'd0);
      if (q >= 0) begin
         check({tag, " qid"}, 32'(bus.o_qid), 32'(q));
         check({tag, " data"}, bus.o_data, word(q, i));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b0;
      for (int q = 0; q < 4; q++) pushed[q] = 0;
`ifdef IQUEUE_ARB_PRIO_EN
      bus.i_hi_prio = '0;
`endif
      repeat (2) @(negedge clk);
      #1;
      check("rst pop", 32'(bus.o_pop), 32'd0);
      check("rst valid", 32'(bus.o_valid), 32'd0);
      check("rst data", bus.o_data, 32'd0);
      check("rst qid", 32'(bus.o_qid), 32'd0);
      check("rst busy", 32'(bus.o_busy), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Round robin over four full queues.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 0) begin
            for (int q = 0; q < 4; q++) pushed[q] += 2;
            bus.i_ready = 1'b1;
         end
         #1;
         check($sformatf("rr pop c%0d", k), 32'(bus.o_pop), (k < 8) ? 32'(1 << (k % 4)) : 32'd0);
         check_issue($sformatf("rr c%0d", k), (k >= 3 && k <= 10) ? (k - 3) % 4 : -1, (k - 3) / 4);
         check($sformatf("rr busy c%0d", k), 32'(bus.o_busy), (k >= 1 && k <= 10) ? 32'd1 : 32'd0);
      end

      // Single queue with consumer stalled, then released.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            pushed[2] += 3;
            bus.i_ready = 1'b0;
         end
         if (k == 6) bus.i_ready = 1'b1;
         #1;
         check($sformatf("q2 pop d%0d", k), 32'(bus.o_pop), (k < 3) ? 32'd4 : 32'd0);
         check_issue($sformatf("q2 d%0d", k), (k >= 3 && k <= 8) ? 2 : -1,
                     (k <= 6) ? 2 : k - 4);
         check($sformatf("q2 busy d%0d", k), 32'(bus.o_busy),
               (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
      end

      // Credit limit with the consumer stalled.
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (k == 0) begin
            for (int q = 0; q < 4; q++) pushed[q] += 2;
            bus.i_ready = 1'b0;
         end
         if (k == 5) bus.i_ready = 1'b1;
         #1;
         check($sformatf("credit pop e%0d", k), 32'(bus.o_pop), 32'(t4_pop[k]));
         check_issue($sformatf("credit e%0d", k), t4_q[k], t4_i[k]);
         if (k == 4 || k == 5) check($sformatf("credit busy e%0d", k), 32'(bus.o_busy), 32'd1);
         if (k == 13) check("credit idle", 32'(bus.o_busy), 32'd0);
      end

      // Flush after two pops.
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k == 0) begin
            pushed[3] += 1;
            pushed[0] += 1;
            pushed[1] += 1;
         end
         bus.i_flush = (k == 2);
         #1;
         check($sformatf("flush pop f%0d", k), 32'(bus.o_pop),
               (k == 0) ? 32'd8 : (k == 1) ? 32'd1 : (k == 3) ? 32'd2 : 32'd0);
         check_issue($sformatf("flush f%0d", k), (k == 6) ? 1 : -1, 4);
         if (k == 3) check("flush busy f3", 32'(bus.o_busy), 32'd0);
      end

      // Asynchronous reset while q0 is streaming; undelivered pops are lost.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) pushed[0] += 5;
         #1;
         check($sformatf("mid pop g%0d", k), 32'(bus.o_pop), 32'd1);
      end
      check_issue("mid g3", 0, 5);
      #2 rst_n = 1'b0;
      #1;
      check("arst pop", 32'(bus.o_pop), 32'd0);
      check("arst valid", 32'(bus.o_valid), 32'd0);
      check("arst data", bus.o_data, 32'd0);
      check("arst qid", 32'(bus.o_qid), 32'd0);
      check("arst busy", 32'(bus.o_busy), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) rst_n = 1'b1;
         #1;
         check($sformatf("post pop h%0d", k), 32'(bus.o_pop), (k < 2) ? 32'd1 : 32'd0);
         check_issue($sformatf("post h%0d", k), (k == 3 || k == 4) ? 0 : -1, k + 5);
      end

`ifdef IQUEUE_ARB_PRIO_EN
      // High-priority q3 drains first, then normal round robin resumes.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.i_hi_prio = 4'b1000;
            pushed[3] += 2;
            for (int q = 0; q < 3; q++) pushed[q] += 1;
         end
         #1;
         check($sformatf("prio pop p%0d", k), 32'(bus.o_pop),
               (k < 2) ? 32'd8 : (k < 5) ? 32'(1 << (k - 2)) : 32'd0);
      end
      bus.i_hi_prio = '0;
`endif

      repeat (6) @(negedge clk);
      #1;
      check("final busy", 32'(bus.o_busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
